// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side (in_*) and execute-side (out_*) handshake bundle; master drives in_* and out_ready, slave is the stage
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_rd_we;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_illegal;
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7, out_imm, out_type, out_rd_we, out_rs1_used, out_rs2_used, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7, out_imm, out_type, out_rd_we, out_rs1_used, out_rs2_used, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode stage with 2-entry skid buffer; ports clk, rst (sync, active-high), flush, bus (in_* from fetch, out_* decoded fields to execute)
module decode_stage #(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1,
  parameter bit LS_EN  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
  } dec_t;
  logic [31:0] inst;
  logic        is_r, is_i, is_u, is_c, is_l, is_s;
  dec_t        dec, or_q, sk_q;
  logic        or_v, sk_v, acc, drain;
  assign inst = bus.in_inst;
  always_comb begin
    is_r = inst[6:0] == 7'b0110011 && (inst[31:25] == 7'b0000000 || inst[31:25] == 7'b0100000);
    is_i = inst[6:0] == 7'b0010011;
    is_u = inst[6:0] == 7'b0110111;
    is_c = CSR_EN && inst[6:0] == 7'b1110011 && inst[14:12] == 3'b001;
    is_l = LS_EN && inst[6:0] == 7'b0000011 && inst[14:12] != 3'b011 && inst[14:12] < 3'b110;
    is_s = LS_EN && inst[6:0] == 7'b0100011 && inst[14:12] < 3'b011;
    dec.pc       = bus.in_pc;
    dec.opcode   = inst[6:0];
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.funct3   = inst[14:12];
    dec.funct7   = inst[31:25];
    dec.typ      = is_r ? 3'd0 : is_i ? 3'd1 : is_u ? 3'd2 : is_c ? 3'd3 : is_l ? 3'd4 : is_s ? 3'd5 : 3'd7;
    dec.imm      = (is_i || is_l) ? XLEN'($signed(inst[31:20])) :
                   is_s ? XLEN'($signed({inst[31:25], inst[11:7]})) :
                   is_u ? XLEN'($signed({inst[31:12], 12'b0})) :
                   is_c ? XLEN'(inst[31:20]) : '0;
    dec.rd_we    = (is_r || is_i || is_u || is_c || is_l) && inst[11:7] != 5'd0;
    dec.rs1_used = is_r || is_i || is_c || is_l || is_s;
    dec.rs2_used = is_r || is_s;
    dec.illegal  = !(is_r || is_i || is_u || is_c || is_l || is_s);
  end
  assign acc   = bus.in_valid && !sk_v;
  assign drain = !or_v || bus.out_ready;
  // SK only fills while OR is held, so when OR drains SK (if any) is always older than a new input
  always_ff @(posedge clk) begin
    if (rst) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
      or_q <= '0;
      sk_q <= '0;
    end else if (flush) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
    end else if (drain) begin
      or_v <= sk_v || acc;
      sk_v <= 1'b0;
      if (sk_v || acc) or_q <= sk_v ? sk_q : dec;
    end else if (acc) begin
      sk_v <= 1'b1;
      sk_q <= dec;
    end
  end
  assign bus.in_ready     = !sk_v;
  assign bus.out_valid    = or_v;
  assign bus.out_pc       = or_q.pc;
  assign bus.out_opcode   = or_q.opcode;
  assign bus.out_rd       = or_q.rd;
  assign bus.out_rs1      = or_q.rs1;
  assign bus.out_rs2      = or_q.rs2;
  assign bus.out_funct3   = or_q.funct3;
  assign bus.out_funct7   = or_q.funct7;
  assign bus.out_imm      = or_q.imm;
  assign bus.out_type     = or_q.typ;
  assign bus.out_rd_we    = or_q.rd_we;
  assign bus.out_rs1_used = or_q.rs1_used;
  assign bus.out_rs2_used = or_q.rs2_used;
  assign bus.out_illegal  = or_q.illegal;
endmodule
